axis_packet_arbiter: RTL and testbench

Packet-aware round-robin merge of PORT_NB slave AXI-Streams onto one master AXI-Stream. It is the converging counterpart to the broadcast fan-out stage: it collects the per-port streams produced by worker lanes and hands a single stream to a downstream consumer. Once a port is granted, it owns the output until its tlast beat is accepted, so packets never interleave. The output is registered and the index of the granted port is reported alongside each beat.

---
 rtl/axis_packet_arbiter.sv | 135 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin merge of PORT_NB AXI-Stream slaves onto one registered master.
// A granted port owns the output until its tlast beat is accepted; m_tid names the source port.
module axis_packet_arbiter #(
  parameter int AXIS_DWIDTH = 32,
  parameter int PORT_NB     = 8,
  localparam int IDW        = (PORT_NB > 1) ? $clog2(PORT_NB) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NB*AXIS_DWIDTH-1:0] s_tdata,
  input  logic [PORT_NB-1:0]             s_tlast,
  input  logic [PORT_NB-1:0]             s_tvalid,
  output logic [PORT_NB-1:0]             s_tready,
  output logic [AXIS_DWIDTH-1:0]         m_tdata,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [IDW-1:0]                 m_tid
);

  // Handshake: a beat moves on an interface at a rising edge where tvalid & tready are both 1;
  // a source holds tvalid and its payload stable until that edge.
  typedef enum logic {ARB, PASS} state_e;

  state_e                   state_q, state_d;
  logic [IDW-1:0]           gnt_q, gnt_d;
  logic [IDW-1:0]           last_q, last_d;
  logic [AXIS_DWIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic [IDW-1:0]           m_tid_q, m_tid_d;

  logic                     found;
  logic [IDW-1:0]           pick;
  logic                     sel_valid, sel_last;
  logic [AXIS_DWIDTH-1:0]   sel_data;
  logic                     in_pass, take, accept;

  // Cyclic scan starting at last+1: ports above last first, then wrap to 0..last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < PORT_NB; j++) begin
      if (!found && s_tvalid[j] && (j > int'(last_q))) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
    for (int j = 0; j < PORT_NB; j++) begin
      if (!found && s_tvalid[j] && (j <= int'(last_q))) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < PORT_NB; j++) begin
      if (int'(gnt_q) == j) begin
        sel_valid = s_tvalid[j];
        sel_last  = s_tlast[j];
        sel_data  = s_tdata[j*AXIS_DWIDTH +: AXIS_DWIDTH];
      end
    end
  end

  // The output register can take a beat when empty or draining on this same edge.
  assign in_pass = (state_q == PASS) && !rst;
  assign take    = !m_tvalid_q || m_tready;
  assign accept  = in_pass && take && sel_valid;

  always_comb begin
    s_tready = '0;
    for (int j = 0; j < PORT_NB; j++) begin
      s_tready[j] = in_pass && take && (int'(gnt_q) == j);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    m_tid_d    = m_tid_q;
    if (state_q == ARB) begin
      if (found) begin
        gnt_d   = pick;
        last_d  = pick;
        state_d = PASS;
      end
    end else if (accept && sel_last) begin
      state_d = ARB;
    end
    if (accept) begin
      m_tdata_d  = sel_data;
      m_tlast_d  = sel_last;
      m_tvalid_d = 1'b1;
      m_tid_d    = gnt_q;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      gnt_q      <= '0;
      last_q     <= IDW'(PORT_NB - 1);
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tid    = m_tid_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios on an 8-port instance and a
// randomized packet-order scoreboard on a 3-port instance.
module tb_axis_packet_arbiter;

  localparam int P8 = 8;
  localparam int DW8 = 32;
  localparam int P3 = 3;
  localparam int DW3 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [P8*DW8-1:0] s8_tdata;
  logic [P8-1:0]     s8_tlast, s8_tvalid, s8_tready;
  logic [DW8-1:0]    m8_tdata;
  logic              m8_tlast, m8_tvalid, m8_tready;
  logic [2:0]        m8_tid;

  logic [P3*DW3-1:0] s3_tdata;
  logic [P3-1:0]     s3_tlast, s3_tvalid, s3_tready;
  logic [DW3-1:0]    m3_tdata;
  logic              m3_tlast, m3_tvalid, m3_tready;
  logic [1:0]        m3_tid;

  axis_packet_arbiter #(.AXIS_DWIDTH(DW8), .PORT_NB(P8)) dut8 (
    .clk(clk), .rst(rst),
    .s_tdata(s8_tdata), .s_tlast(s8_tlast), .s_tvalid(s8_tvalid), .s_tready(s8_tready),
    .m_tdata(m8_tdata), .m_tlast(m8_tlast), .m_tvalid(m8_tvalid), .m_tready(m8_tready),
    .m_tid(m8_tid)
  );

  axis_packet_arbiter #(.AXIS_DWIDTH(DW3), .PORT_NB(P3)) dut3 (
    .clk(clk), .rst(rst),
    .s_tdata(s3_tdata), .s_tlast(s3_tlast), .s_tvalid(s3_tvalid), .s_tready(s3_tready),
    .m_tdata(m3_tdata), .m_tlast(m3_tlast), .m_tvalid(m3_tvalid), .m_tready(m3_tready),
    .m_tid(m3_tid)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk8(input logic [2:0] tid, input logic last, input logic [31:0] data);
    return {tid, last, data};
  endfunction

  // ---------------- 8-port source/sink engine ----------------
  logic [32:0] src8_q[P8][$];
  logic [35:0] log_q[$];
  int          log_cyc[$];
  int          slog_cyc[$];
  logic [P8-1:0] en8 = '0;
  logic        mrdy8 = 1'b1;
  int          stall_left = 0;
  logic [31:0] stall_val = '0;
  logic        watch5 = 1'b0;
  int          rdy5_bad = 0;

  logic [P8-1:0] hs8;
  logic        mhs8, pstall8, prst8;
  logic [35:0] pbeat8;
  int          cyc;

  initial begin
    logic [32:0] h;
    s8_tvalid = '0; s8_tlast = '0; s8_tdata = '0; m8_tready = 1'b1;
    hs8 = '0; mhs8 = 1'b0; pstall8 = 1'b0; prst8 = 1'b1; pbeat8 = '0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < P8; p++)
        if (hs8[p] && src8_q[p].size() > 0) void'(src8_q[p].pop_front());
      for (int p = 0; p < P8; p++) begin
        s8_tvalid[p] = en8[p] && (src8_q[p].size() > 0);
        h = s8_tvalid[p] ? src8_q[p][0] : 33'd0;
        s8_tlast[p] = h[32];
        s8_tdata[p*DW8 +: DW8] = h[31:0];
      end
      m8_tready = mrdy8;
      if (stall_left > 0 && m8_tvalid && m8_tdata == stall_val) begin
        m8_tready = 1'b0;
        stall_left--;
      end
      #3;
      hs8  = s8_tvalid & s8_tready;
      mhs8 = m8_tvalid & m8_tready & ~rst;
      if (|hs8) slog_cyc.push_back(cyc);
      if (mhs8) begin
        log_q.push_back({m8_tid, m8_tlast, m8_tdata});
        log_cyc.push_back(cyc);
      end
      if (watch5 && s8_tready[5]) rdy5_bad++;
      if (!rst) begin
        if (pstall8 && !prst8) begin
          check("m8_hold_valid", m8_tvalid, 1);
          check("m8_hold_beat", {m8_tlast, m8_tid, m8_tdata}, pbeat8);
        end
        if (m8_tlast) check("m8_last_needs_valid", m8_tvalid, 1);
        check("s8_ready_onehot", $countones(s8_tready) > 1, 0);
      end
      pstall8 = m8_tvalid & ~m8_tready;
      pbeat8  = {m8_tlast, m8_tid, m8_tdata};
      prst8   = rst;
    end
  end

  // ---------------- 3-port random engine + scoreboard ----------------
  logic [16:0] src3_q[P3][$];
  logic [16:0] exp_q[P3][$];
  logic [P3-1:0] hs3;
  logic        mhs3, pstall3, prst3, in_pkt3;
  logic [1:0]  cur_tid3;
  logic [18:0] pbeat3;

  initial begin
    logic [16:0] h3;
    int tid;
    s3_tvalid = '0; s3_tlast = '0; s3_tdata = '0; m3_tready = 1'b1;
    hs3 = '0; mhs3 = 1'b0; pstall3 = 1'b0; prst3 = 1'b1; in_pkt3 = 1'b0;
    cur_tid3 = '0; pbeat3 = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < P3; p++)
        if (hs3[p] && src3_q[p].size() > 0) void'(src3_q[p].pop_front());
      for (int p = 0; p < P3; p++) begin
        if (!(s3_tvalid[p] && !hs3[p]))
          s3_tvalid[p] = (src3_q[p].size() > 0) && ($urandom_range(0, 3) != 0);
        h3 = s3_tvalid[p] ? src3_q[p][0] : 17'd0;
        s3_tlast[p] = h3[16];
        s3_tdata[p*DW3 +: DW3] = h3[15:0];
      end
      m3_tready = ($urandom_range(0, 9) < 7);
      #3;
      hs3  = s3_tvalid & s3_tready;
      mhs3 = m3_tvalid & m3_tready & ~rst;
      if (!rst) begin
        if (mhs3) begin
          tid = int'(m3_tid);
          check("m3_tid_range", tid < P3, 1);
          if (in_pkt3) check("m3_no_interleave", m3_tid, cur_tid3);
          if (tid < P3) begin
            check("m3_beat_expected", exp_q[tid].size() > 0, 1);
            if (exp_q[tid].size() > 0)
              check("m3_beat", {m3_tlast, m3_tdata}, exp_q[tid].pop_front());
          end
          in_pkt3  = !m3_tlast;
          cur_tid3 = m3_tid;
        end
        if (pstall3 && !prst3) begin
          check("m3_hold_valid", m3_tvalid, 1);
          check("m3_hold_beat", {m3_tlast, m3_tid, m3_tdata}, pbeat3);
        end
        if (m3_tlast) check("m3_last_needs_valid", m3_tvalid, 1);
        check("s3_ready_onehot", $countones(s3_tready) > 1, 0);
      end
      pstall3 = m3_tvalid & ~m3_tready;
      pbeat3  = {m3_tlast, m3_tid, m3_tdata};
      prst3   = rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear8();
    for (int p = 0; p < P8; p++) src8_q[p].delete();
    log_q.delete(); log_cyc.delete(); slog_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en8 = '0; mrdy8 = 1'b1; stall_left = 0; watch5 = 1'b0;
    step(); step();
    check("rst_m_tvalid", m8_tvalid, 0);
    check("rst_m_tlast", m8_tlast, 0);
    check("rst_m_tdata", m8_tdata, 0);
    check("rst_m_tid", m8_tid, 0);
    check("rst_s_tready", s8_tready, 0);
    check("rst_m3_tvalid", m3_tvalid, 0);
    clear8();
    rst = 1'b0;
    step();
    check("post_rst_s_tready", s8_tready, 0);
  endtask

  task automatic wait_log(input int n);
    int b = 0;
    while (log_q.size() < n && b < 200) begin
      step();
      b++;
    end
    check("log_timeout", log_q.size() >= n, 1);
  endtask

  task automatic push_pkt8(input int p, input logic [31:0] base, input int len);
    for (int k = 0; k < len; k++) src8_q[p].push_back({k == len - 1, base + 32'(k)});
  endtask

  task automatic gen_pkt3(input int p);
    int len;
    logic [16:0] beat;
    len = $urandom_range(1, 5);
    for (int k = 0; k < len; k++) begin
      beat = {k == len - 1, 16'($urandom_range(0, 65535))};
      src3_q[p].push_back(beat);
      exp_q[p].push_back(beat);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int b;
    do_reset();

    // Two 4-beat packets on ports 0 and 3: port 0 first, one bubble between packets.
    push_pkt8(0, 32'h100, 4);
    push_pkt8(3, 32'h300, 4);
    en8 = '1;
    wait_log(8);
    for (int k = 0; k < 8; k++) begin
      check("t1_beat", log_q[k], mk8((k < 4) ? 3'd0 : 3'd3, (k % 4) == 3,
            ((k < 4) ? 32'h100 : 32'h300) + 32'(k % 4)));
      if (k > 0) check("t1_gap", log_cyc[k] - log_cyc[k-1], (k == 4) ? 2 : 1);
    end

    // All ports offer single-beat packets: grants rotate 0..7,0,1.
    do_reset();
    for (int p = 0; p < P8; p++) begin
      push_pkt8(p, 32'(p), 1);
      push_pkt8(p, 32'(p), 1);
    end
    en8 = '1;
    wait_log(10);
    for (int k = 0; k < 10; k++)
      check("t2_rotate", log_q[k], mk8(3'(k % 8), 1'b1, 32'(k % 8)));

    // Port 2 A,B,C with a 3-cycle stall on B; port 5 arrives after A and must wait.
    do_reset();
    src8_q[2].push_back({1'b0, 32'hA0A0_000A});
    src8_q[2].push_back({1'b0, 32'hB0B0_000B});
    src8_q[2].push_back({1'b1, 32'hC0C0_000C});
    push_pkt8(5, 32'h500, 2);
    stall_val = 32'hB0B0_000B;
    stall_left = 3;
    watch5 = 1'b1;
    en8 = 8'b0000_0100;
    b = 0;
    while (src8_q[2].size() == 3 && b < 50) begin
      step();
      b++;
    end
    check("t3_a_taken", src8_q[2].size() < 3, 1);
    en8[5] = 1'b1;
    wait_log(3);
    watch5 = 1'b0;
    wait_log(5);
    check("t3_a", log_q[0], mk8(3'd2, 1'b0, 32'hA0A0_000A));
    check("t3_b", log_q[1], mk8(3'd2, 1'b0, 32'hB0B0_000B));
    check("t3_c", log_q[2], mk8(3'd2, 1'b1, 32'hC0C0_000C));
    check("t3_p5_0", log_q[3], mk8(3'd5, 1'b0, 32'h500));
    check("t3_p5_1", log_q[4], mk8(3'd5, 1'b1, 32'h501));
    check("t3_b_stall", log_cyc[1] - log_cyc[0], 4);
    check("t3_rdy5_blocked", rdy5_bad, 0);

    // 16-beat packet on port 1: full throughput, 1-cycle latency, tlast only on beat 16.
    do_reset();
    push_pkt8(1, 32'h1000, 16);
    en8 = 8'b0000_0010;
    wait_log(16);
    for (int k = 0; k < 16; k++) begin
      check("t4_beat", log_q[k], mk8(3'd1, k == 15, 32'h1000 + 32'(k)));
      check("t4_latency", log_cyc[k] - slog_cyc[k], 1);
      if (k > 0) check("t4_rate", log_cyc[k] - log_cyc[k-1], 1);
    end

    // Reset while port 4's first beat is stalled on m; arbitration restarts at port 0.
    do_reset();
    push_pkt8(4, 32'h400, 4);
    stall_val = 32'h400;
    stall_left = 1000;
    en8 = 8'b0001_0000;
    b = 0;
    while (!(m8_tvalid && m8_tdata == 32'h400) && b < 50) begin
      step();
      b++;
    end
    check("t5_held_beat", m8_tvalid && m8_tdata == 32'h400, 1);
    step();
    push_pkt8(6, 32'h600, 1);
    en8 = 8'b0101_0000;
    rst = 1'b1;
    step();
    check("t5_rst_tvalid", m8_tvalid, 0);
    check("t5_rst_tlast", m8_tlast, 0);
    check("t5_rst_tid", m8_tid, 0);
    log_q.delete(); log_cyc.delete(); slog_cyc.delete();
    stall_left = 0;
    rst = 1'b0;
    wait_log(4);
    check("t5_rest_0", log_q[0], mk8(3'd4, 1'b0, 32'h401));
    check("t5_rest_1", log_q[1], mk8(3'd4, 1'b0, 32'h402));
    check("t5_rest_2", log_q[2], mk8(3'd4, 1'b1, 32'h403));
    check("t5_p6", log_q[3], mk8(3'd6, 1'b1, 32'h600));

    // Random traffic on the 3-port instance, checked per port against generated packets.
    en8 = '0;
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int p = 0; p < P3; p++)
        if (src3_q[p].size() < 4) gen_pkt3(p);
    end
    b = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && b < 3000) begin
      step();
      b++;
    end
    check("t6_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    check("t6_sources_empty", src3_q[0].size() + src3_q[1].size() + src3_q[2].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
